// File: rtl/fir_ch_arbiter_pkg.sv
// Shared FSM encoding and round-robin index helper for the FIR channel arbiter.
package fir_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic int rr_idx(input int last, input int offset, input int n);
        return (last + offset) % n;
    endfunction

endpackage

// File: rtl/fir_ch_arbiter_if.sv
// Stream bundle around the arbiter: NUM_CH source channels in, one muxed stream toward the FIR.
// master = arbiter side, slave = sources plus FIR sink.
interface fir_ch_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 4
);
    logic [NUM_CH*DATA_WIDTH-1:0] s_tdata;
    logic [NUM_CH-1:0]            s_tvalid;
    logic [NUM_CH-1:0]            s_tlast;
    logic [NUM_CH-1:0]            s_tready;
    logic [DATA_WIDTH-1:0]        m_tdata;
    logic                         m_tvalid;
    logic                         m_tready;
    logic                         m_tlast;
    logic [$clog2(NUM_CH)-1:0]    m_tid;

    modport master (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast, m_tid
    );

    modport slave (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast, m_tid
    );
endinterface

// File: rtl/fir_ch_arbiter_rr_prio_enc.sv
// Combinational rotate-priority encoder: first requester strictly after last_i, wrapping to 0.
module rr_prio_enc
    import fir_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         req_i,
    input  logic [$clog2(NUM_CH)-1:0] last_i,
    output logic [$clog2(NUM_CH)-1:0] idx_o,
    output logic                      any_o
);
    localparam int ID_W = $clog2(NUM_CH);

    logic [ID_W-1:0] cand;

    // Walk from the farthest offset to the nearest so the nearest requester wins.
    always_comb begin
        idx_o = '0;
        cand  = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            cand = ID_W'(rr_idx(int'(last_i), i, NUM_CH));
            if (req_i[cand]) begin
                idx_o = cand;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/fir_ch_arbiter.sv
// Round-robin N:1 sample arbiter toward the FIR; 1-cycle registered output, s_tready only when output slot free.
// FIR_ARB_PKT_LOCK_EN: hold grant until tlast or MAX_BEATS; undefined: release after every beat.
module fir_ch_arbiter
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int MAX_BEATS  = 29
) (
    input  logic             clk_i,
    input  logic             arst_i,
    fir_ch_arbiter_if.master bus
);
    localparam int               ID_W     = $clog2(NUM_CH);
    localparam int               CNT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

    arb_state_e            state_q;
    logic [ID_W-1:0]       ptr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] m_tdata_q;
    logic                  m_tvalid_q;
    logic                  m_tlast_q;
    logic [ID_W-1:0]       m_tid_q;

    logic [ID_W-1:0]       nxt_idx;
    logic                  any_vld;
    logic [NUM_CH-1:0]     rdy_w;
    logic                  acc;
    logic                  acc_last;
    logic                  pkt_end;
    logic                  cnt_max;
    logic                  rel;
    logic [DATA_WIDTH-1:0] sel_dat;

    rr_prio_enc #(.NUM_CH(NUM_CH)) u_enc (
        .req_i  (bus.s_tvalid),
        .last_i (ptr_q),
        .idx_o  (nxt_idx),
        .any_o  (any_vld)
    );

    always_comb begin
        rdy_w = '0;
        if (state_q == GRANT) begin
            rdy_w[ptr_q] = ~m_tvalid_q | bus.m_tready;
        end
    end

    assign acc      = rdy_w[ptr_q] & bus.s_tvalid[ptr_q];
    assign acc_last = bus.s_tlast[ptr_q];
    assign sel_dat  = bus.s_tdata[int'(ptr_q)*DATA_WIDTH +: DATA_WIDTH];
    assign cnt_max  = (cnt_q == CNT_LAST);

`ifdef FIR_ARB_PKT_LOCK_EN
    assign pkt_end = acc_last;
`else
    assign pkt_end = 1'b1;
`endif

    // tlast and the beat limit fold into one release, so the pointer only moves in IDLE.
    assign rel = acc & (pkt_end | cnt_max);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= IDLE;
            ptr_q      <= ID_W'(NUM_CH - 1);
            cnt_q      <= '0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tid_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_vld) begin
                        state_q <= GRANT;
                        ptr_q   <= nxt_idx;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (acc) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (acc) begin
                m_tdata_q  <= sel_dat;
                m_tlast_q  <= acc_last;
                m_tid_q    <= ptr_q;
                m_tvalid_q <= 1'b1;
            end else if (bus.m_tready) begin
                m_tvalid_q <= 1'b0;
            end
        end
    end

    assign bus.s_tready = rdy_w;
    assign bus.m_tdata  = m_tdata_q;
    assign bus.m_tvalid = m_tvalid_q;
    assign bus.m_tlast  = m_tlast_q;
    assign bus.m_tid    = m_tid_q;

endmodule

// File: tb/tb_fir_ch_arbiter.sv
// Bench for fir_ch_arbiter: directed scenarios plus randomized packets against a transaction-level round-robin model.
module tb_fir_ch_arbiter;
    localparam int DW   = 16;
    localparam int NCH  = 4;
    localparam int MAXB = 4;
`ifdef FIR_ARB_PKT_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    typedef struct packed { logic [15:0] d; logic l; } beat_t;
    typedef struct packed { logic [1:0] id; logic [15:0] d; logic l; } obeat_t;

    logic   clk  = 1'b0;
    logic   arst = 1'b0;
    int     n_pass  = 0;
    int     n_fail  = 0;
    int     n_total = 0;
    int     mdl_ptr = NCH - 1;
    beat_t  srcq [NCH][$];
    obeat_t expq [$];
    int     acc_cyc [$];
    logic [1:0] out_tid [$];

    fir_ch_arbiter_if #(.DATA_WIDTH(DW), .NUM_CH(NCH)) ifc ();

    fir_ch_arbiter #(.DATA_WIDTH(DW), .NUM_CH(NCH), .MAX_BEATS(MAXB)) dut (
        .clk_i  (clk),
        .arst_i (arst),
        .bus    (ifc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int c, input logic [15:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        srcq[c].push_back(b);
    endtask

    task automatic drive_srcs(input logic rdy);
        logic [NCH*DW-1:0] d;
        logic [NCH-1:0]    v;
        logic [NCH-1:0]    l;
        d = '0; v = '0; l = '0;
        for (int c = 0; c < NCH; c++) begin
            if (srcq[c].size() > 0) begin
                d[c*DW +: DW] = srcq[c][0].d;
                v[c] = 1'b1;
                l[c] = srcq[c][0].l;
            end
        end
        ifc.s_tdata  = d;
        ifc.s_tvalid = v;
        ifc.s_tlast  = l;
        ifc.m_tready = rdy;
    endtask

    // Round-robin over non-empty channels; a grant covers one beat, or (locked) up to tlast / MAXB beats.
    task automatic model_predict();
        beat_t  q [NCH][$];
        beat_t  b;
        obeat_t e;
        int     c, n;
        bit     more;
        expq.delete();
        for (int i = 0; i < NCH; i++) q[i] = srcq[i];
        more = 1'b1;
        while (more) begin
            c = -1;
            for (int k = 1; k <= NCH; k++)
                if (c < 0 && q[(mdl_ptr + k) % NCH].size() > 0) c = (mdl_ptr + k) % NCH;
            if (c < 0) begin
                more = 1'b0;
            end else begin
                n = 0;
                do begin
                    b = q[c].pop_front();
                    n++;
                    e.id = 2'(c); e.d = b.d; e.l = b.l;
                    expq.push_back(e);
                end while (LOCK && !b.l && n < MAXB && q[c].size() > 0);
                mdl_ptr = c;
            end
        end
    endtask

    task automatic do_reset();
        arst = 1'b1;
        #1;
        chk("rst_m_tvalid", ifc.m_tvalid, 0);
        chk("rst_m_tdata",  ifc.m_tdata,  0);
        chk("rst_m_tid",    ifc.m_tid,    0);
        chk("rst_m_tlast",  ifc.m_tlast,  0);
        chk("rst_s_tready", ifc.s_tready, 0);
        ifc.s_tdata  = '0;
        ifc.s_tvalid = '0;
        ifc.s_tlast  = '0;
        ifc.m_tready = 1'b0;
        for (int c = 0; c < NCH; c++) srcq[c].delete();
        expq.delete();
        mdl_ptr = NCH - 1;
        repeat (2) @(posedge clk);
        #2;
        arst = 1'b0;
    endtask

    // rdy_mode: 0 always ready, 1 random ready, 2 ready low for cycles 3..7. stop_acc>0 leaves after that many accepts.
    task automatic run(input int rdy_mode, input int stop_acc);
        int     cyc, nacc;
        bit     done, pv_stall, empty;
        logic [15:0] pv_d;
        logic [1:0]  pv_id;
        logic        pv_l, rdy;
        logic [NCH-1:0] acc;
        obeat_t e;
        beat_t  b;
        cyc = 0; nacc = 0; done = 1'b0; pv_stall = 1'b0;
        pv_d = '0; pv_id = '0; pv_l = 1'b0;
        acc_cyc.delete();
        out_tid.delete();
        model_predict();
        while (!done && cyc < 600) begin
            case (rdy_mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 9) < 7);
                default: rdy = !(cyc >= 3 && cyc < 8);
            endcase
            drive_srcs(rdy);
            #1;
            if (pv_stall) begin
                chk("hold_m_tvalid", ifc.m_tvalid, 1);
                chk("hold_m_tdata",  ifc.m_tdata,  pv_d);
                chk("hold_m_tid",    ifc.m_tid,    pv_id);
                chk("hold_m_tlast",  ifc.m_tlast,  pv_l);
            end
            chk("s_tready_onehot0", $onehot0(ifc.s_tready), 1);
            if (ifc.m_tvalid && !ifc.m_tready) chk("stall_s_tready", ifc.s_tready, 0);
            if (ifc.m_tvalid && ifc.m_tready) begin
                e = 'x;
                if (expq.size() > 0) e = expq.pop_front();
                chk("out_tid",   ifc.m_tid,   e.id);
                chk("out_tdata", ifc.m_tdata, e.d);
                chk("out_tlast", ifc.m_tlast, e.l);
                out_tid.push_back(ifc.m_tid);
            end
            pv_stall = ifc.m_tvalid && !ifc.m_tready;
            pv_d  = ifc.m_tdata;
            pv_id = ifc.m_tid;
            pv_l  = ifc.m_tlast;
            acc   = ifc.s_tvalid & ifc.s_tready;
            @(posedge clk);
            #2;
            for (int c = 0; c < NCH; c++) begin
                if (acc[c]) begin
                    b = srcq[c].pop_front();
                    chk("lat_m_tvalid", ifc.m_tvalid, 1);
                    chk("lat_m_tdata",  ifc.m_tdata,  b.d);
                    chk("lat_m_tid",    ifc.m_tid,    c);
                    chk("lat_m_tlast",  ifc.m_tlast,  b.l);
                    acc_cyc.push_back(cyc);
                    nacc++;
                end
            end
            cyc++;
            empty = 1'b1;
            for (int c = 0; c < NCH; c++) if (srcq[c].size() > 0) empty = 1'b0;
            if (stop_acc > 0 && nacc >= stop_acc) done = 1'b1;
            else if (empty && expq.size() == 0 && !ifc.m_tvalid) done = 1'b1;
        end
        if (stop_acc == 0) begin
            chk("run_finished", done, 1);
            chk("exp_left", expq.size(), 0);
        end
    endtask

    initial begin
        #3;
        do_reset();

        // Channel 2 alone, 3-beat packet.
        push(2, 16'h0011, 1'b0); push(2, 16'h0022, 1'b0); push(2, 16'h0033, 1'b1);
        run(0, 0);
        chk("b_nout", out_tid.size(), 3);
        chk("b_first_acc_cyc", acc_cyc[0], 1);
        chk("b_beat_spacing", acc_cyc[1] - acc_cyc[0], LOCK ? 1 : 2);

        // All channels, single-beat packets: 0,1,2,3,0 with one IDLE cycle between grants.
        do_reset();
        for (int c = 0; c < NCH; c++) push(c, 16'h0A00 + 16'(c), 1'b1);
        push(0, 16'h0A10, 1'b1);
        run(0, 0);
        chk("c_nout", out_tid.size(), 5);
        for (int i = 0; i < 5; i++) chk("c_order", out_tid[i], i % NCH);
        for (int i = 1; i < 5; i++) chk("c_spacing", acc_cyc[i] - acc_cyc[i-1], 2);

        // Channel 1 with 10 beats and no tlast, channel 3 waiting.
        do_reset();
        for (int i = 0; i < 10; i++) push(1, 16'h0100 + 16'(i), 1'b0);
        push(3, 16'h3301, 1'b0); push(3, 16'h3302, 1'b1);
        run(0, 0);
        chk("d_nout", out_tid.size(), 12);
        chk("d_before_rel", out_tid[LOCK ? 3 : 0], 1);
        chk("d_after_rel",  out_tid[LOCK ? 4 : 1], 3);

        // Output stall for 5 cycles mid-packet.
        do_reset();
        for (int i = 0; i < 4; i++) push(0, 16'h5500 + 16'(i), i == 3);
        run(2, 0);
        chk("e_nout", out_tid.size(), 4);

        // Reset during beat 2 of a 4-beat packet on channel 3.
        do_reset();
        for (int i = 0; i < 4; i++) push(3, 16'h3000 + 16'(i), i == 3);
        run(0, 1);
        drive_srcs(1'b1);
        #1;
        chk("f_pre_rst_vld", ifc.m_tvalid, 1);
        do_reset();
        push(0, 16'h0A0A, 1'b1);
        push(3, 16'h3B01, 1'b1);
        run(0, 0);
        chk("f_nout", out_tid.size(), 2);
        chk("f_first_tid", out_tid[0], 0);
        chk("f_second_tid", out_tid[1], 3);

        // Channels 0 and 1 continuously valid: grants alternate.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push(0, 16'h0C00 + 16'(i), 1'b1);
            push(1, 16'h1C00 + 16'(i), 1'b1);
        end
        run(0, 0);
        chk("g_nout", out_tid.size(), 6);
        for (int i = 0; i < 6; i++) chk("g_alternate", out_tid[i], i % 2);

        // Randomized packets with random output backpressure.
        for (int r = 0; r < 6; r++) begin
            int npk, len;
            do_reset();
            for (int c = 0; c < NCH; c++) begin
                npk = $urandom_range(0, 2);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(1, 6);
                    for (int i = 0; i < len; i++) push(c, 16'($urandom), i == len - 1);
                end
            end
            run(1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
